// File: rtl/proc_pkg.sv
// Shared types and defaults for the program sequencer and its processor.
package proc_pkg;

    localparam int unsigned InstrW         = 16;
    localparam int unsigned WdogMaxDefault = 7;

    typedef logic [InstrW-1:0] instr_t;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StIssue,
        StWait,
        StPause,
        StHalted,
        StError
    } seq_state_e;

endpackage

// File: rtl/proc_sequencer_if.sv
// Program-ROM and processor handshake bundle driven by the sequencer.
interface proc_sequencer_if
    import proc_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) ();

    logic [ADDR_W-1:0] MemAddr;
    instr_t            MemRdata;
    instr_t            DIN;
    logic              Run;
    logic              Done;

    modport master (
        output MemAddr,
        output DIN,
        output Run,
        input  MemRdata,
        input  Done
    );

    modport slave (
        input  MemAddr,
        input  DIN,
        input  Run,
        output MemRdata,
        output Done
    );

endinterface

// File: rtl/seq_watchdog.sv
// Counts stalled WAIT cycles; expired fires on the cycle the count would reach WDOG_MAX.
module seq_watchdog
    import proc_pkg::*;
#(
    parameter int unsigned WDOG_MAX = WdogMaxDefault
) (
    input  logic Clock,
    input  logic Resetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CntW = $clog2(WDOG_MAX + 1);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    assign expired = enable && (cnt_q == CntW'(WDOG_MAX - 1));

endmodule

// File: rtl/proc_sequencer.sv
// Fetches instructions from a synchronous ROM and issues them one at a time to the processor.
module proc_sequencer
    import proc_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned LAST_ADDR = 255,
    parameter int unsigned WDOG_MAX  = WdogMaxDefault
) (
    input  logic                    Clock,
    input  logic                    Resetn,
    input  logic                    Start,
    input  logic                    HaltReq,
    input  logic                    StepMode,
    proc_sequencer_if.master        bus,
    output logic                    Busy,
    output logic [InstrW-1:0]       InstrCount,
    output logic                    Halted,
    output logic                    Error
);

    localparam logic [ADDR_W-1:0] LastPc = ADDR_W'(LAST_ADDR);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    instr_t            din_q, din_d;
    logic [InstrW-1:0] count_q, count_d;
    logic              wd_clear, wd_enable, wd_expired;

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q <= StIdle;
            pc_q    <= '0;
            din_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            din_q   <= din_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        din_d   = din_q;
        count_d = count_q;
        unique case (state_q)
            StIdle:  if (Start) state_d = StFetch;
            StFetch: state_d = StLoad;
            StLoad: begin
                din_d   = bus.MemRdata;
                state_d = StIssue;
            end
            StIssue: state_d = StWait;
            StWait: begin
                if (bus.Done) begin
                    count_d = count_q + 16'd1;
                    if (HaltReq || (pc_q == LastPc)) begin
                        state_d = StHalted;
                    end else begin
                        pc_d    = pc_q + ADDR_W'(1);
                        state_d = StepMode ? StPause : StFetch;
                    end
                end else if (wd_expired) begin
                    state_d = StError;
                end
            end
            // Halt wins over a simultaneous resume.
            StPause: begin
                if (HaltReq)    state_d = StHalted;
                else if (Start) state_d = StFetch;
            end
            StHalted: state_d = StHalted;
            StError:  state_d = StError;
            default:  state_d = StIdle;
        endcase
    end

    assign wd_clear  = (state_q == StIssue);
    assign wd_enable = (state_q == StWait) && !bus.Done;

    seq_watchdog #(
        .WDOG_MAX (WDOG_MAX)
    ) u_watchdog (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    // PC only moves at instruction completion, so it is stable throughout FETCH.
    assign bus.MemAddr = pc_q;
    assign bus.DIN     = din_q;
    assign bus.Run     = (state_q == StIssue);
    assign Busy        = !(state_q inside {StIdle, StHalted, StError});
    assign InstrCount  = count_q;
    assign Halted      = (state_q == StHalted);
    assign Error       = (state_q == StError);

endmodule

// File: tb/tb_proc_sequencer.sv
// Scoreboard bench: ROM and processor models, expected DIN words checked at each Run pulse.
module tb_proc_sequencer;

    localparam logic [3:0] OpMv  = 4'd0;
    localparam logic [3:0] OpAdd = 4'd1;
    localparam logic [3:0] OpSub = 4'd2;

    logic        Clock;
    logic        Resetn;
    logic        Start;
    logic        HaltReq;
    logic        StepMode;
    logic        Busy;
    logic [15:0] InstrCount;
    logic        Halted;
    logic        Error;

    proc_sequencer_if #(.ADDR_W(8)) bus ();

    proc_sequencer #(
        .ADDR_W    (8),
        .LAST_ADDR (2),
        .WDOG_MAX  (7)
    ) dut (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .Start      (Start),
        .HaltReq    (HaltReq),
        .StepMode   (StepMode),
        .bus        (bus),
        .Busy       (Busy),
        .InstrCount (InstrCount),
        .Halted     (Halted),
        .Error      (Error)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ROM model: one-cycle read latency
    logic [15:0] rom [0:255];
    always @(posedge Clock) bus.MemRdata <= rom[bus.MemAddr];

    // Processor model: mv takes one step, add/sub take two
    logic        p_busy;
    logic [1:0]  p_step;
    logic [15:0] p_ir;
    logic [15:0] regs [0:3];
    logic        force_done_low;
    logic [1:0]  p_len;

    assign p_len    = (p_ir[15:12] == OpMv) ? 2'd1 : 2'd2;
    assign bus.Done = !force_done_low && p_busy && (p_step == p_len);

    always @(posedge Clock) begin
        if (!Resetn) begin
            p_busy <= 1'b0;
            p_step <= 2'd0;
            p_ir   <= 16'd0;
            for (int i = 0; i < 4; i++) regs[i] <= 16'd0;
        end else if (bus.Run) begin
            p_busy <= 1'b1;
            p_step <= 2'd1;
            p_ir   <= bus.DIN;
        end else if (p_busy) begin
            if (bus.Done) begin
                p_busy <= 1'b0;
                case (p_ir[15:12])
                    OpMv:    regs[p_ir[9:8]] <= {8'd0, p_ir[7:0]};
                    OpAdd:   regs[p_ir[9:8]] <= regs[p_ir[9:8]] + {8'd0, p_ir[7:0]};
                    default: regs[p_ir[9:8]] <= regs[p_ir[9:8]] - {8'd0, p_ir[7:0]};
                endcase
            end else begin
                p_step <= p_step + 2'd1;
            end
        end
    end

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [1:0] r,
                                        input logic [7:0] imm);
        return {op, 2'b00, r, imm};
    endfunction

    // Scoreboard and output monitor, sampled on the falling edge
    logic [15:0] exp_q [$];
    int          run_count;
    int          cyc_n = 0;
    int          run_cyc [0:7];
    logic [7:0]  max_addr;
    logic [15:0] last_din;

    always @(negedge Clock) begin
        cyc_n++;
        if (!Resetn) begin
            run_count = 0;
            max_addr  = 8'd0;
        end else begin
            if (bus.MemAddr > max_addr) max_addr = bus.MemAddr;
            if (bus.Run) begin
                if (run_count < 8) run_cyc[run_count] = cyc_n;
                run_count++;
                last_din = bus.DIN;
                if (exp_q.size() == 0) check("run_unexpected", 32'd1, 32'd0);
                else check("din_issue", bus.DIN, exp_q.pop_front());
            end
            if (bus.Done && Busy) check("din_stable", bus.DIN, last_din);
        end
    end

    task automatic cyc();
        @(negedge Clock);
        #1;
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        cyc();
        Start = 1'b0;
    endtask

    task automatic do_reset();
        exp_q.delete();
        Resetn   = 1'b0;
        Start    = 1'b0;
        HaltReq  = 1'b0;
        StepMode = 1'b0;
        force_done_low = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = 16'd0;
        cyc();
        cyc();
        Resetn = 1'b1;
    endtask

    task automatic wait_runs(input int n, input int budget);
        int i = 0;
        while (run_count < n && i < budget) begin
            cyc();
            i++;
        end
        if (run_count < n) check("timeout_run", run_count, n);
    endtask

    task automatic wait_count(input int n, input int budget);
        int i = 0;
        while (int'(InstrCount) < n && i < budget) begin
            cyc();
            i++;
        end
        if (int'(InstrCount) < n) check("timeout_count", InstrCount, n);
    endtask

    task automatic wait_end(input int budget);
        int i = 0;
        while (!Halted && !Error && i < budget) begin
            cyc();
            i++;
        end
        if (!Halted && !Error) check("timeout_end", 32'd0, 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},   Busy, 0);
        check({tag, "_run"},    bus.Run, 0);
        check({tag, "_halted"}, Halted, 0);
        check({tag, "_error"},  Error, 0);
        check({tag, "_count"},  InstrCount, 0);
        check({tag, "_din"},    bus.DIN, 0);
        check({tag, "_addr"},   bus.MemAddr, 0);
    endtask

    initial begin
        // Reset values
        do_reset();
        Resetn = 1'b0;
        cyc();
        check_idle_outputs("reset");
        Resetn = 1'b1;
        repeat (3) cyc();
        check("idle_hold_busy", Busy, 0);

        // Three-instruction program runs to LAST_ADDR
        rom[0] = enc(OpMv, 2'd0, 8'd5);
        rom[1] = enc(OpAdd, 2'd0, 8'd3);
        rom[2] = enc(OpSub, 2'd0, 8'd1);
        for (int i = 0; i < 3; i++) exp_q.push_back(rom[i]);
        pulse_start();
        wait_runs(1, 20);
        pulse_start();   // ignored while running
        wait_end(100);
        check("prog_halted", Halted, 1);
        check("prog_count", InstrCount, 3);
        check("prog_runs", run_count, 3);
        check("prog_r0", regs[0], 7);
        check("prog_busy", Busy, 0);
        check("prog_error", Error, 0);
        check("prog_max_addr", max_addr, 2);
        check("prog_sb_empty", exp_q.size(), 0);
        check("mv_gap", run_cyc[1] - run_cyc[0], 4);
        check("add_gap", run_cyc[2] - run_cyc[1], 5);
        repeat (4) cyc();
        check("halted_terminal", Halted, 1);

        // Step mode with resume, then simultaneous Start and HaltReq in PAUSE
        do_reset();
        StepMode = 1'b1;
        rom[0] = enc(OpMv, 2'd1, 8'd9);
        rom[1] = enc(OpAdd, 2'd1, 8'd1);
        exp_q.push_back(rom[0]);
        pulse_start();
        wait_count(1, 30);
        check("step_count0", InstrCount, 1);
        check("step_busy", Busy, 1);
        repeat (5) cyc();
        check("step_paused_runs", run_count, 1);
        exp_q.push_back(rom[1]);
        pulse_start();
        wait_count(2, 30);
        cyc();
        check("step_runs", run_count, 2);
        check("step_not_halted", Halted, 0);
        Start   = 1'b1;
        HaltReq = 1'b1;
        cyc();
        Start   = 1'b0;
        HaltReq = 1'b0;
        check("step_halted", Halted, 1);
        check("step_count1", InstrCount, 2);
        check("step_r1", regs[1], 10);

        // HaltReq during WAIT of the first instruction
        do_reset();
        rom[0] = enc(OpAdd, 2'd2, 8'd4);
        rom[1] = enc(OpAdd, 2'd2, 8'd4);
        rom[2] = enc(OpAdd, 2'd2, 8'd4);
        rom[3] = enc(OpAdd, 2'd2, 8'd4);
        exp_q.push_back(rom[0]);
        pulse_start();
        wait_runs(1, 20);
        HaltReq = 1'b1;
        wait_end(30);
        HaltReq = 1'b0;
        check("hreq_halted", Halted, 1);
        check("hreq_count", InstrCount, 1);
        check("hreq_max_addr", max_addr, 0);
        check("hreq_runs", run_count, 1);

        // Watchdog expiry with Done stuck low
        do_reset();
        force_done_low = 1'b1;
        rom[0] = enc(OpMv, 2'd3, 8'd1);
        exp_q.push_back(rom[0]);
        pulse_start();
        wait_runs(1, 20);
        repeat (7) cyc();
        check("wdog_early", Error, 0);
        cyc();
        check("wdog_error", Error, 1);
        check("wdog_busy", Busy, 0);
        repeat (3) cyc();
        check("wdog_terminal", Error, 1);
        check("wdog_runs", run_count, 1);

        // Reset in the middle of WAIT of instruction 1, then restart
        do_reset();
        rom[0] = enc(OpAdd, 2'd1, 8'd2);
        rom[1] = enc(OpAdd, 2'd1, 8'd3);
        rom[2] = enc(OpSub, 2'd1, 8'd1);
        exp_q.push_back(rom[0]);
        exp_q.push_back(rom[1]);
        pulse_start();
        wait_runs(2, 40);
        cyc();
        check("mid_count", InstrCount, 1);
        Resetn = 1'b0;
        cyc();
        check_idle_outputs("midrst");
        Resetn = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 3; i++) exp_q.push_back(rom[i]);
        cyc();
        pulse_start();
        wait_end(100);
        check("restart_halted", Halted, 1);
        check("restart_count", InstrCount, 3);
        check("restart_r1", regs[1], 4);
        check("restart_sb_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/proc_sequencer.md
PROC_SEQUENCER -- requirements
Module: proc_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, program-memory address width.
REQ-002 SHALL have parameter LAST_ADDR, default 255, final program address; execution stops after it.
REQ-003 SHALL have parameter WDOG_MAX, default 7, maximum wait cycles for Done before error.
REQ-004 Clock  input  1  rising-edge clock for all state.
REQ-005 Resetn  input  1  reset, synchronous, active-low.
REQ-006 Start  input  1  single-cycle pulse: begin run from IDLE, or resume from PAUSE.
REQ-007 HaltReq  input  1  level: stop after the current instruction completes.
REQ-008 StepMode  input  1  level: pause after every instruction.
REQ-009 MemAddr  output  ADDR_W  synchronous program-ROM read address.
REQ-010 MemRdata  input  16  ROM read data, valid one cycle after MemAddr is presented.
REQ-011 DIN  output  16  instruction word to the processor.
REQ-012 Run  output  1  processor start strobe.
REQ-013 Done  input  1  processor completion, combinational from the processor, high in its final time step.
REQ-014 Busy  output  1  high in every state except IDLE, HALTED and ERROR.
REQ-015 InstrCount  output  16  number of completed instructions.
REQ-016 Halted  output  1  high in HALTED.
REQ-017 Error  output  1  high in ERROR (watchdog expiry).

Function
REQ-018 States SHALL be IDLE, FETCH, LOAD, ISSUE, WAIT, PAUSE, HALTED and ERROR.
REQ-019 IDLE SHALL go to FETCH on Start=1 and otherwise hold.
REQ-020 FETCH SHALL drive MemAddr=PC for one cycle, then go to LOAD.
REQ-021 LOAD SHALL capture MemRdata into the DIN register at the end of the cycle, then go to ISSUE.
REQ-022 ISSUE SHALL assert Run=1 for exactly one cycle with DIN stable, then go to WAIT.
REQ-023 DIN SHALL remain unchanged from LOAD until the next LOAD.
REQ-024 WAIT SHALL hold Run=0 and sample Done every cycle, including the first cycle after ISSUE (1-step instructions).
REQ-025 On Done=1 in WAIT, the block SHALL increment InstrCount, wrapping modulo 2^16.
REQ-026 On Done=1 in WAIT, the next state SHALL be chosen in this priority order:
- HaltReq=1 or PC==LAST_ADDR: HALTED.
- StepMode=1: PAUSE, with PC+1.
- Otherwise: FETCH, with PC+1.
REQ-027 PC SHALL be ADDR_W bits, start at 0, and increment only per REQ-026; it never wraps past LAST_ADDR.
REQ-028 PAUSE SHALL go to FETCH on Start=1.
REQ-029 HaltReq=1 in PAUSE SHALL move the block to HALTED.
REQ-030 Watchdog counter SHALL clear on entry to WAIT and increment each WAIT cycle with Done=0.
REQ-031 When the watchdog reaches WDOG_MAX with Done=0, the block SHALL go to ERROR.
REQ-032 HALTED and ERROR SHALL be terminal until reset.
REQ-033 Start SHALL be ignored outside IDLE and PAUSE.
REQ-034 HaltReq SHALL be ignored in IDLE, FETCH, LOAD and ISSUE; it takes effect only at instruction completion or in PAUSE.
REQ-035 HaltReq and Done both 1 in the same WAIT cycle SHALL count the instruction and go to HALTED.
REQ-036 Start and HaltReq both 1 in PAUSE SHALL go to HALTED.

Reset
REQ-037 With Resetn=0 at a rising edge, the block SHALL enter IDLE from any state, including mid-WAIT.
REQ-038 Reset values: PC=0, MemAddr=0, DIN=0, Run=0, Busy=0, InstrCount=0, Halted=0, Error=0, watchdog=0.
REQ-039 The processor SHALL share Resetn, so a reset mid-instruction leaves both blocks in their initial step.

Structure
REQ-040 State encoding, WDOG_MAX default and the 16-bit instruction width SHALL live in a shared package, proc_pkg.
REQ-041 The watchdog SHALL be a sub-module seq_watchdog with inputs clear and enable and a single expired output.

Verification
REQ-042 ROM[0..2] = mv r0,#5; add r0,#3; sub r0,#1; LAST_ADDR=2; Start pulse -> three Run pulses; Halted=1; InstrCount=3; processor r0=7.
REQ-043 StepMode=1, two-instruction program -> PAUSE after instr 0 with InstrCount=1; Start -> instr 1 issued; Halted=1; InstrCount=2.
REQ-044 HaltReq raised during WAIT of instr 0 of a 4-instruction program -> HALTED after instr 0; InstrCount=1; MemAddr never reaches 1.
REQ-045 Done tied low -> ERROR exactly WDOG_MAX=7 cycles after entering WAIT; Run pulsed once; Busy=0.
REQ-046 Resetn=0 for one cycle during WAIT of instr 1 -> IDLE next cycle; all outputs 0; Start then restarts from address 0.
REQ-047 mv instruction, Done high in the first WAIT cycle -> next FETCH on the following cycle; DIN unchanged from LOAD through WAIT.
